lcd_responder: RTL

Synthesizable responder for the two-chip KS0108-style graphic LCD bus that `Driver` initiates on: it decodes the `db/dori/cs/en/rw/rst` strobes, executes display commands, stores written bytes in a 2×8×64 display RAM, and answers status and data reads. It stands in for the physical panel in simulation and on-chip loopback, and exposes a readback port so a checker can compare panel RAM against the framebuffer.

---
 rtl/lcd_pkg.sv | 44 ++++
 rtl/lcd_half.sv | 82 ++++++++
 rtl/lcd_responder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared opcodes, status bit positions and address field widths
// for the KS0108-style panel responder.
package lcd_pkg;

  localparam int PAGE_W = 3;
  localparam int Y_W    = 6;
  localparam int RAM_AW = PAGE_W + Y_W;

  localparam logic [7:0] OP_ON_M    = 8'hFE;
  localparam logic [7:0] OP_ON      = 8'h3E;
  localparam logic [7:0] OP_Y_M     = 8'hC0;
  localparam logic [7:0] OP_Y       = 8'h40;
  localparam logic [7:0] OP_PAGE_M  = 8'hF8;
  localparam logic [7:0] OP_PAGE    = 8'hB8;
  localparam logic [7:0] OP_START_M = 8'hC0;
  localparam logic [7:0] OP_START   = 8'hC0;

  localparam int ST_BUSY = 7;
  localparam int ST_OFF  = 5;
  localparam int ST_RST  = 4;

  typedef enum logic [2:0] {
    CMD_BAD,
    CMD_ON,
    CMD_Y,
    CMD_PAGE,
    CMD_START
  } cmd_e;

  function automatic cmd_e decode(input logic [7:0] b);
    cmd_e c;
    c = CMD_BAD;
    if ((b & OP_ON_M) == OP_ON)
      c = CMD_ON;
    else if ((b & OP_Y_M) == OP_Y)
      c = CMD_Y;
    else if ((b & OP_PAGE_M) == OP_PAGE)
      c = CMD_PAGE;
    else if ((b & OP_START_M) == OP_START)
      c = CMD_START;
    return c;
  endfunction

endpackage

// File: rtl/lcd_half.sv
// lcd_half: one panel chip - page/y/on/start registers, busy counter,
// 512x8 display RAM, dummy-read latch and a synchronous readback port.
// Ports: cmd_we/data_we/data_re are pre-qualified commit strobes,
// din is the committed byte, rb_addr/rb_data the readback port.
module lcd_half
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pnl_rst_n,
  input  logic              cmd_we,
  input  logic              data_we,
  input  logic              data_re,
  input  logic [7:0]        din,
  input  logic [RAM_AW-1:0] rb_addr,
  output logic [7:0]        rb_data,
  output logic              busy,
  output logic              on,
  output logic [Y_W-1:0]    start,
  output logic [7:0]        rd_buf
);

  localparam int CW = $clog2(BUSY_CYCLES + 1);

  logic [7:0]        mem [2**RAM_AW];
  logic [PAGE_W-1:0] page;
  logic [Y_W-1:0]    y;
  logic [CW-1:0]     busy_cnt;
  logic [RAM_AW-1:0] addr;

  assign addr = {page, y};
  assign busy = (busy_cnt != '0);

  // RAM has no reset: contents survive both resets
  always_ff @(posedge clk) begin
    if (data_we)
      mem[addr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_data  <= '0;
      on       <= 1'b0;
      start    <= '0;
      page     <= '0;
      y        <= '0;
      busy_cnt <= '0;
      rd_buf   <= '0;
    end else begin
      rb_data <= mem[rb_addr];
      if (!pnl_rst_n) begin
        on       <= 1'b0;
        start    <= '0;
        page     <= '0;
        y        <= '0;
        busy_cnt <= '0;
      end else begin
        if (busy)
          busy_cnt <= busy_cnt - 1'b1;
        if (cmd_we || data_we || data_re)
          busy_cnt <= CW'(BUSY_CYCLES);
        if (cmd_we) begin
          case (decode(din))
            CMD_ON:    on    <= din[0];
            CMD_Y:     y     <= din[Y_W-1:0];
            CMD_PAGE:  page  <= din[PAGE_W-1:0];
            CMD_START: start <= din[Y_W-1:0];
            default:   ;
          endcase
        end
        // y wraps 63->0 without touching page
        if (data_we || data_re)
          y <= y + 1'b1;
        if (data_re)
          rd_buf <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/lcd_responder.sv
// lcd_responder: two-chip graphic LCD bus responder. Captures the bus
// while en_i is high, commits on its falling edge, muxes read data and
// status onto db_o, keeps the sticky viol_o flag and the readback port.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pnl_rst_n_i,
  input  logic [7:0]  db_i,
  input  logic        dori_i,
  input  logic [1:0]  cs_i,
  input  logic        en_i,
  input  logic        rw_i,
  output logic [7:0]  db_o,
  output logic        db_oe_o,
  input  logic [9:0]  rd_addr_i,
  output logic [7:0]  rd_data_o,
  output logic [1:0]  disp_on_o,
  output logic [11:0] start_line_o,
  output logic        viol_o
);

  logic             en_q, dori_q, rw_q, rb_half_q;
  logic [7:0]       db_q;
  logic [1:0]       cs_q;
  logic             fall, both_rd, cmd_ok, status_rd;
  logic             is_cmd, viol_set;
  logic [1:0]       busy, on, live, acc;
  logic [1:0]       cmd_we, data_we, data_re;
  logic [1:0][7:0]  rd_buf, rb_data;
  logic [1:0][Y_W-1:0] start;
  logic             sel;
  logic [7:0]       status;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q      <= 1'b0;
      db_q      <= '0;
      dori_q    <= 1'b0;
      rw_q      <= 1'b0;
      cs_q      <= '0;
      rb_half_q <= 1'b0;
    end else begin
      en_q      <= en_i;
      rb_half_q <= rd_addr_i[9];
      if (en_i) begin
        db_q   <= db_i;
        dori_q <= dori_i;
        rw_q   <= rw_i;
        cs_q   <= cs_i;
      end
    end
  end

  assign fall      = en_q & ~en_i;
  assign both_rd   = rw_q & (cs_q == 2'b11);
  assign status_rd = rw_q & ~dori_q;
  assign is_cmd    = ~rw_q & ~dori_q;
  assign cmd_ok    = (decode(db_q) != CMD_BAD);

  // live: a state-changing commit aimed at a half; acc: it is not busy
  always_comb begin
    live = '0;
    acc  = '0;
    if (fall && pnl_rst_n_i && !both_rd && !status_rd) begin
      live = cs_q;
      acc  = cs_q & ~busy;
    end
  end

  assign cmd_we  = acc & {2{is_cmd & cmd_ok}};
  assign data_we = acc & {2{dori_q & ~rw_q}};
  assign data_re = acc & {2{dori_q & rw_q}};

  assign viol_set = fall & pnl_rst_n_i &
                    (both_rd | (|(live & busy)) |
                     (|acc & is_cmd & ~cmd_ok));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      viol_o <= 1'b0;
    else if (viol_set)
      viol_o <= 1'b1;
  end

  for (genvar h = 0; h < 2; h++) begin : g_half
    lcd_half #(
      .BUSY_CYCLES(BUSY_CYCLES)
    ) u_half (
      .clk       (clk),
      .rst       (rst),
      .pnl_rst_n (pnl_rst_n_i),
      .cmd_we    (cmd_we[h]),
      .data_we   (data_we[h]),
      .data_re   (data_re[h]),
      .din       (db_q),
      .rb_addr   (rd_addr_i[RAM_AW-1:0]),
      .rb_data   (rb_data[h]),
      .busy      (busy[h]),
      .on        (on[h]),
      .start     (start[h]),
      .rd_buf    (rd_buf[h])
    );
  end

  assign sel     = cs_i[1];
  assign db_oe_o = en_i & rw_i & (^cs_i);

  always_comb begin
    status          = '0;
    status[ST_BUSY] = busy[sel];
    status[ST_OFF]  = ~on[sel];
    status[ST_RST]  = ~pnl_rst_n_i;
    db_o            = '0;
    if (db_oe_o)
      db_o = dori_i ? rd_buf[sel] : status;
  end

  assign rd_data_o    = rb_data[rb_half_q];
  assign disp_on_o    = on;
  assign start_line_o = {start[1], start[0]};

endmodule
